// File: rtl/code_sequence_tx.sv
// code_sequence_tx: serial code-stream transmitter feeding the sequence detector.
// A captured pattern is sent MSB-first, one bit per clock. The burst can be
// repeated reps+1 times with GAP idle cycles between bursts. All outputs are
// registers that are updated together with the state.
module code_sequence_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             code,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [REP_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_cnt;

  logic [WIDTH-1:0] aligned;
  logic             len_legal;
  logic             last_bit;

  // Left-justify the requested bits so the first bit to send sits at the MSB.
  assign aligned   = pattern << (MAX_LEN - len);
  assign len_legal = (len != '0) && (len <= MAX_LEN);
  assign last_bit  = (bit_cnt == len_q - LEN_W'(1));

  // Transmit FSM: state, datapath and the registered outputs move together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      bit_cnt  <= '0;
      rep_left <= '0;
      gap_cnt  <= '0;
      code     <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        code  <= 1'b0;
        valid <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (len_legal) begin
                shreg    <= aligned;
                pat_q    <= aligned;
                len_q    <= len;
                rep_left <= reps;
                bit_cnt  <= '0;
                state    <= S_SEND;
                code     <= aligned[WIDTH-1];
                valid    <= 1'b1;
                busy     <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end

          S_SEND: begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + LEN_W'(1);
            if (last_bit) begin
              if (rep_left == '0) begin
                state <= S_DONE;
                code  <= 1'b0;
                valid <= 1'b0;
                done  <= 1'b1;
              end else if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= '0;
                code    <= 1'b0;
                valid   <= 1'b0;
              end else begin
                shreg    <= pat_q;
                rep_left <= rep_left - REP_W'(1);
                bit_cnt  <= '0;
                code     <= pat_q[WIDTH-1];
                valid    <= 1'b1;
              end
            end else begin
              code  <= shreg[WIDTH-2];
              valid <= 1'b1;
            end
          end

          S_GAP: begin
            if (gap_cnt == GAP_END) begin
              shreg    <= pat_q;
              rep_left <= rep_left - REP_W'(1);
              bit_cnt  <= '0;
              state    <= S_SEND;
              code     <= pat_q[WIDTH-1];
              valid    <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end

          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= S_IDLE;
            code  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/code_sequence_tx.md
# code_sequence_tx

Serial code-stream transmitter: the sending end of the single-bit `code` line consumed by the Moore sequence-detector FSM. It loads a pattern word and shifts it out MSB-first, one bit per clock. It can repeat the burst a programmed number of times, with an idle gap between bursts. It sits in front of the detector in both system and bench use, and drives `code` directly.

## Interface
- `WIDTH`, 8, maximum pattern length in bits (≥2)
- `LEN_W`, 4, width of `len`; must hold `WIDTH`
- `REP_W`, 4, width of `reps`
- `GAP`, 2, idle cycles between repeated bursts (0 = back-to-back)
- `clock`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  request transmission; sampled only in IDLE
- `abort`  input  1  synchronous cancel; any state → IDLE
- `pattern`  input  WIDTH  bits `pattern[len-1:0]` are sent, `pattern[len-1]` first
- `len`  input  LEN_W  burst length, legal 1..WIDTH
- `reps`  input  REP_W  extra repetitions; total bursts = `reps`+1
- `code`  output  1  serial data line to detector
- `valid`  output  1  high while `code` carries a pattern bit
- `busy`  output  1  high in SEND, GAP, DONE
- `done`  output  1  one-cycle pulse after the final bit
- `err`  output  1  one-cycle pulse on a rejected `start`

## Operation
- Moore FSM; all outputs are registered and decoded from state/datapath regs only.
- States: IDLE, SEND, GAP, DONE.
- IDLE: `code`=0, `valid`=0, `busy`=0.
  - On `start`=1 with legal `len`: capture `shreg` = `pattern << (WIDTH-len)`, `len`, and `rep_left` = `reps`; clear `bit_cnt`; go to SEND.
  - On `start`=1 with `len`=0 or `len`>WIDTH: pulse `err`; stay in IDLE; capture nothing.
- SEND: `code` = `shreg[WIDTH-1]`, `valid`=1.
  - Each cycle: shift left by 1 and increment `bit_cnt`.
  - After the `len`-th bit:
    - if `rep_left`=0 → DONE;
    - else if `GAP`>0 → GAP;
    - else reload `shreg` from the captured pattern, decrement `rep_left`, clear `bit_cnt`, and stay in SEND.
- GAP: `code`=0, `valid`=0 for exactly `GAP` cycles. Reload `shreg` and decrement `rep_left`, then → SEND.
- DONE: `done`=1, `code`=0, `valid`=0 for one cycle → IDLE.
- `start` is ignored in SEND, GAP and DONE; no queuing, no `err`.
- `abort` has priority over all transitions, including `start` in IDLE. Next state is IDLE, with no `done` and no `err`.
- `reset` (asynchronous) clears the state to IDLE and every output and internal register to 0 immediately, at any point, including mid-burst.
- Captured `pattern`/`len`/`reps` are held internally; input changes during a transmission have no effect.

## Timing
- Reset values: `code`=0, `valid`=0, `busy`=0, `done`=0, `err`=0.
- `start` sampled at edge k → first bit on `code` with `valid`=1 and `busy`=1 in the cycle after edge k (latency 1).
- Single burst: `valid` high for exactly `len` cycles. `done` is high in cycle k+`len`+1, then `busy`=0 from edge k+`len`+1.
- Multi-burst total busy span = (`reps`+1)·`len` + `reps`·`GAP` + 1 cycles.
- `err`: high in the cycle after the rejecting edge, for one cycle.
- `abort` sampled at edge m → `busy`=`valid`=`code`=0 after edge m.
- A new `start` is accepted in the first IDLE cycle after DONE, i.e. back-to-back transmissions have a minimum one-cycle spacing.

## Test plan
- Reset: hold `reset`=1 for 2 cycles → all outputs 0. Assert `reset` mid-SEND at a non-edge time → `code`/`valid`/`busy` drop to 0 without waiting for a clock edge.
- Basic burst: `pattern`=8'h06, `len`=3, `reps`=0 → `code`=1,1,0 with `valid`=1 on cycles k+1..k+3; `done`=1 at k+4; `busy`=0 at k+5.
- Repeat with gap (`GAP`=2): `pattern`=8'h0B, `len`=4, `reps`=2 → 1011, then 00 with `valid`=0, then 1011, then 00, then 1011, then `done`. Busy span is 17 cycles.
- Back-to-back (`GAP`=0 instance): `pattern`=8'hA5, `len`=8, `reps`=1 → 16 contiguous `valid` cycles carrying 10100101 10100101, then `done`.
- Illegal length: `len`=0 → `err` pulse, `busy` stays 0. Repeat with `len`=9 → same result.
- Busy/abort: pulse `start` with new data during SEND → ignored, and the original stream completes intact. Assert `abort` at bit 2 → IDLE next cycle, no `done`. An immediately following `start` is accepted normally.
